// File: rtl/hyperbus_wb_bridge.sv
// rtl/hyperbus_wb_bridge.sv - Wishbone classic single-beat slave feeding the HyperBus leader controller.
// Holds wrq/rrq until one word moves, then terminates with ack (or err on timeout) and enforces an idle gap.
module hyperbus_wb_bridge #(
  parameter int WIDTH       = 8,
  parameter int ADDR_LENGTH = 32,
  parameter int TIMEOUT     = 255,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                     clk90,
  input  logic                     rst,
  input  logic [ADDR_LENGTH-1:0]   wb_adr_i,
  input  logic [2*WIDTH-1:0]       wb_dat_i,
  input  logic [2*WIDTH/8-1:0]     wb_sel_i,
  input  logic                     wb_we_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  output logic [2*WIDTH-1:0]       wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic [ADDR_LENGTH-1:0]   hb_adr_o,
  output logic [2*WIDTH-1:0]       hb_dat_o,
  output logic [2*WIDTH/8:0]       hb_mask_o,
  output logic                     hb_reg_space_o,
  output logic                     hb_wrq_o,
  output logic                     hb_rrq_o,
  input  logic                     hb_ready_i,
  input  logic                     hb_valid_i,
  input  logic [2*WIDTH-1:0]       hb_dat_i
);

  localparam int DW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH / 8;
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    WRITE = 4'b0010,
    READ  = 4'b0100,
    GAP   = 4'b1000
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [7:0]              cnt_inc;
  logic [ADDR_LENGTH-1:0]  adr_q, adr_d;
  logic [DW-1:0]           dat_q, dat_d;
  logic [SW:0]             mask_q, mask_d;
  logic                    reg_q, reg_d;
  logic                    wrq_q, wrq_d;
  logic                    rrq_q, rrq_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [DW-1:0]           rdat_q, rdat_d;

  // Byte-address bit 0 is intentionally dropped: odd addresses map to the containing word.
  logic unused_adr0;
  assign unused_adr0 = wb_adr_i[0];

  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_ff @(posedge clk90 or posedge rst) begin
    if (rst) begin
      state_q <= GAP;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      mask_q  <= '0;
      reg_q   <= 1'b0;
      wrq_q   <= 1'b0;
      rrq_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      mask_q  <= mask_d;
      reg_q   <= reg_d;
      wrq_q   <= wrq_d;
      rrq_q   <= rrq_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    mask_d  = mask_q;
    reg_d   = reg_q;
    wrq_d   = wrq_q;
    rrq_d   = rrq_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdat_d  = rdat_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (wb_cyc_i && wb_stb_i) begin
          adr_d  = {2'b00, wb_adr_i[ADDR_LENGTH-2:1]};
          reg_d  = wb_adr_i[ADDR_LENGTH-1];
          dat_d  = wb_dat_i;
          mask_d = {1'b0, ~wb_sel_i};
          if (wb_we_i) begin
            wrq_d   = 1'b1;
            state_d = WRITE;
          end else begin
            rrq_d   = 1'b1;
            state_d = READ;
          end
        end
      end

      WRITE: begin
        cnt_d = cnt_inc;
        if (!wb_cyc_i) begin
          wrq_d   = 1'b0;
          rrq_d   = 1'b0;
          cnt_d   = '0;
          state_d = GAP;
        end else if (hb_ready_i) begin
          // All-ones mask neutralises any extra word clocked before wrq is seen low.
          wrq_d   = 1'b0;
          mask_d  = '1;
          ack_d   = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end else if (cnt_q >= TO_LAST) begin
          wrq_d   = 1'b0;
          rrq_d   = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end
      end

      READ: begin
        cnt_d = cnt_inc;
        if (!wb_cyc_i) begin
          wrq_d   = 1'b0;
          rrq_d   = 1'b0;
          cnt_d   = '0;
          state_d = GAP;
        end else if (hb_valid_i) begin
          rdat_d  = hb_dat_i;
          rrq_d   = 1'b0;
          ack_d   = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end else if (cnt_q >= TO_LAST) begin
          wrq_d   = 1'b0;
          rrq_d   = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end
      end

      GAP: begin
        wrq_d = 1'b0;
        rrq_d = 1'b0;
        if (cnt_q >= GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        wrq_d   = 1'b0;
        rrq_d   = 1'b0;
        cnt_d   = '0;
        state_d = GAP;
      end
    endcase
  end

  assign wb_dat_o       = rdat_q;
  assign wb_ack_o       = ack_q;
  assign wb_err_o       = err_q;
  assign hb_adr_o       = adr_q;
  assign hb_dat_o       = dat_q;
  assign hb_mask_o      = mask_q;
  assign hb_reg_space_o = reg_q;
  assign hb_wrq_o       = wrq_q;
  assign hb_rrq_o       = rrq_q;

endmodule

// File: doc/hyperbus_wb_bridge.md
# hyperbus_wb_bridge

Wishbone B4 classic single-beat slave that turns bus cycles into request/handshake sequences for the HyperBus leader controller. It sits directly upstream of the controller. It latches address, data and byte selects, and holds `wrq`/`rrq` until exactly one 16-bit word has moved. It then returns `ack`, or `err` on timeout. It also enforces the inter-transaction gap the controller needs to return to idle.

## Interface
Parameters:
- `WIDTH`, 8, HyperBus DQ width; the word width is 2*WIDTH.
- `ADDR_LENGTH`, 32, width of the Wishbone and controller addresses.
- `TIMEOUT`, 255, maximum clk90 cycles from request to handshake; range 1..255.
- `GAP_CYCLES`, 4, minimum clk90 cycles with both requests low between transactions; minimum 4.

Ports:
- `clk90`, in, 1, bridge clock. Same frequency as the controller clock, 90° phase shifted.
- `rst`, in, 1, reset; asynchronous, active-high.
- `wb_adr_i`, in, ADDR_LENGTH, byte address. Bit [ADDR_LENGTH-1] selects register space.
- `wb_dat_i`, in, 2*WIDTH, write data.
- `wb_sel_i`, in, 2*WIDTH/8, byte selects.
- `wb_we_i`, `wb_cyc_i`, `wb_stb_i`, in, 1 each, standard Wishbone controls.
- `wb_dat_o`, out, 2*WIDTH, read data.
- `wb_ack_o`, `wb_err_o`, out, 1 each, single-cycle termination pulses.
- `hb_adr_o`, out, ADDR_LENGTH, word address to the controller.
- `hb_dat_o`, out, 2*WIDTH, write word to the controller.
- `hb_mask_o`, out, 2*WIDTH/8+1, RWDS write mask; 1 = byte masked. The MSB is always 0.
- `hb_reg_space_o`, out, 1, register-space select.
- `hb_wrq_o`, `hb_rrq_o`, out, 1 each, write/read request, held until done.
- `hb_ready_i`, in, 1, controller is in its write-data phase.
- `hb_valid_i`, in, 1, controller read-word strobe; a one-clk pulse.
- `hb_dat_i`, in, 2*WIDTH, controller read word.

## Operation
- **States:** IDLE, WRITE, READ, GAP. Encode one-hot; any illegal encoding returns to GAP.
- **IDLE:**
  - Acceptance condition: `wb_cyc_i & wb_stb_i`.
  - On acceptance, latch the request fields:
    - `hb_adr_o` = {1'b0, wb_adr_i[ADDR_LENGTH-2:1]}.
    - `hb_reg_space_o` = wb_adr_i[ADDR_LENGTH-1].
    - `hb_dat_o` = wb_dat_i.
    - `hb_mask_o` = {1'b0, ~wb_sel_i}.
  - Clear the timeout counter.
  - If `wb_we_i`, set `hb_wrq_o` and go to WRITE; otherwise set `hb_rrq_o` and go to READ.
- **WRITE:**
  - On the first cycle with `hb_ready_i`=1:
    - Clear `hb_wrq_o`.
    - Force `hb_mask_o` to all ones.
    - Pulse `wb_ack_o`.
    - Go to GAP.
  - The all-ones mask ensures that any extra word the controller clocks before it sees `wrq` low writes nothing.
- **READ:**
  - On the first cycle with `hb_valid_i`=1:
    - Load `wb_dat_o` = hb_dat_i.
    - Clear `hb_rrq_o`.
    - Pulse `wb_ack_o`.
    - Go to GAP.
  - Ignore further valid pulses until the next READ.
- **Timeout:**
  - In WRITE or READ, the counter increments each cycle.
  - When it reaches TIMEOUT without a handshake, clear both requests, pulse `wb_err_o` (not ack) and go to GAP.
  - `wb_dat_o` is unchanged on timeout.
- **Abort:** if `wb_cyc_i` drops in WRITE or READ, clear the requests and go to GAP, with no ack or err.
- **GAP:**
  - Both requests are low and the counter counts GAP_CYCLES; then go to IDLE.
  - `wb_stb_i` is ignored in GAP.
- **Width rules:**
  - The timeout and gap counters are 8 bits and saturate; they never wrap.
  - Address bit 0 is dropped, so odd byte addresses map to the containing word.

## Timing
- **Reset:** all outputs 0 and state GAP with counter 0. The first request is accepted no earlier than GAP_CYCLES+1 cycles after reset release.
- **Request outputs:** `hb_wrq_o`/`hb_rrq_o` assert on the edge after acceptance. Address, data, mask and reg_space are stable from that edge until the state leaves WRITE/READ.
- **Handshake to termination:** the ack pulse is registered and appears on the edge after the ready/valid sample. Requests drop on that same edge.
- **Ack/err pulses:** each lasts exactly one cycle, and at most one of `wb_ack_o`/`wb_err_o` pulses per accepted cycle.
- **Master obligations:** the master holds `wb_stb_i` until termination and may re-assert it immediately. The next acceptance is ≥GAP_CYCLES+1 cycles after termination.
- **Simultaneous events:**
  - A handshake in the same cycle as timeout expiry wins: ack, no err.
  - A handshake in the same cycle as `wb_cyc_i` falling is treated as an abort, with no ack.
- **Reset mid-transaction:** requests drop immediately (asynchronously) and no termination is issued.

## Test plan
- **Write:** wb_adr=0x0000_0010, dat=0xA55A, sel=2'b11, ready asserted 6 cycles after wrq.
  - Expect hb_adr=0x8 and mask=3'b000.
  - Expect one ack on the cycle after ready, mask=3'b111 from that edge, and wrq low.
- **Byte-masked register write:** adr=0x8000_0002, sel=2'b01.
  - Expect reg_space=1, hb_adr=0x1 and mask=3'b010.
- **Read with burst:** hb_dat=0x1234 with 4 valid pulses.
  - Expect wb_dat_o=0x1234 from the first pulse only, one ack, and rrq low on the next edge.
- **Timeout:** TIMEOUT=10, ready never asserted.
  - Expect err exactly 10 cycles after wrq rises, no ack, and wrq low.
- **Back-to-back:** stb re-asserted right after an ack.
  - Expect both requests low for GAP_CYCLES cycles before the next request.
- **Reset and abort:**
  - rst during READ: rrq drops immediately and no ack is issued.
  - cyc drops mid-WRITE: no ack and no err.
